// File: rtl/ci_pkg.sv
// rtl/ci_pkg.sv - shared state encoding and FP constants for the CI sum driver
package ci_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    NEXT,
    DONE,
    ERROR
  } ci_state_t;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - DEPTH x 32 sample buffer with flush; head is the oldest entry
module sample_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [31:0]                push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [31:0]                head
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0] mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ci_sum_driver.sv
// rtl/ci_sum_driver.sv - drives a multicycle custom-instruction slave to fold buffered samples into a running sum
module ci_sum_driver #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_valid,
  input  logic [31:0] wr_data,
  output logic        wr_ready,
  input  logic        run,
  output logic        busy,
  output logic        result_valid,
  output logic [31:0] result,
  output logic        error,
  output logic        ci_clk_en,
  output logic        ci_start,
  output logic [31:0] ci_dataa,
  output logic [31:0] ci_datab,
  input  logic        ci_done,
  input  logic [31:0] ci_result
);

  import ci_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  ci_state_t     state, state_n;
  logic [31:0]   sum, sum_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic          err_n;
  logic          push, pop, flush;
  logic          full, empty, full_n;
  logic [CW-1:0] count;
  logic [31:0]   head;

  assign push = wr_valid && wr_ready;

  sample_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (wr_data),
    .pop       (pop),
    .flush     (flush),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .head      (head)
  );

  // Buffer fullness after this edge, so wr_ready can be registered.
  assign full_n = !flush && ((full && !pop) || (push && count == CW'(DEPTH - 1)));

  always_comb begin
    state_n = state;
    sum_n   = sum;
    tcnt_n  = tcnt;
    err_n   = error;
    pop     = 1'b0;
    flush   = 1'b0;
    case (state)
      IDLE: begin
        if (run) begin
          err_n   = 1'b0;
          sum_n   = FP_ZERO;
          state_n = empty ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        tcnt_n  = '0;
        state_n = WAIT;
      end
      WAIT: begin
        if (ci_done) begin
          sum_n   = ci_result;
          pop     = 1'b1;
          state_n = (count > CW'(1)) ? NEXT : DONE;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          flush   = 1'b1;
          err_n   = 1'b1;
          state_n = ERROR;
        end else begin
          tcnt_n = tcnt + 1'b1;
        end
      end
      NEXT:    state_n = ISSUE;
      DONE:    state_n = IDLE;
      ERROR:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Every output is a flop loaded from the next state, so it is valid in the state's own cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      sum          <= FP_ZERO;
      tcnt         <= '0;
      wr_ready     <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result       <= FP_ZERO;
      error        <= 1'b0;
      ci_clk_en    <= 1'b0;
      ci_start     <= 1'b0;
      ci_dataa     <= FP_ZERO;
      ci_datab     <= FP_ZERO;
    end else begin
      state        <= state_n;
      sum          <= sum_n;
      tcnt         <= tcnt_n;
      error        <= err_n;
      wr_ready     <= (state_n == IDLE) && !full_n;
      busy         <= (state_n != IDLE);
      ci_start     <= (state_n == ISSUE);
      ci_clk_en    <= (state_n == ISSUE) || (state_n == WAIT);
      result_valid <= (state_n == DONE) || (state_n == ERROR);
      if ((state_n == DONE) || (state_n == ERROR)) result <= sum_n;
      if (state_n == ISSUE) begin
        ci_dataa <= head;
        ci_datab <= sum_n;
      end
    end
  end

endmodule

// File: tb/tb_ci_sum_driver.sv
// tb/tb_ci_sum_driver.sv - directed bench for ci_sum_driver with a fixed-latency +1.0 slave stub
module tb_ci_sum_driver;

  import ci_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        run;
  logic        busy;
  logic        result_valid;
  logic [31:0] result;
  logic        error;
  logic        ci_clk_en;
  logic        ci_start;
  logic [31:0] ci_dataa;
  logic [31:0] ci_datab;
  logic        ci_done;
  logic [31:0] ci_result;

  int checks   = 0;
  int failures = 0;

  int lat       = 5;
  bit stub_dead = 1'b0;
  int stub_cnt;
  logic [31:0] stub_held;

  int starts = 0;
  int gaps   = 0;
  logic [31:0] dataa_q[$];
  logic [31:0] datab_q[$];

  always #5 clk = ~clk;

  ci_sum_driver #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .run          (run),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result),
    .error        (error),
    .ci_clk_en    (ci_clk_en),
    .ci_start     (ci_start),
    .ci_dataa     (ci_dataa),
    .ci_datab     (ci_datab),
    .ci_done      (ci_done),
    .ci_result    (ci_result)
  );

  function automatic logic [31:0] plus_one(input logic [31:0] x);
    case (x)
      FP_ZERO:      return FP_ONE;
      32'h3F800000: return 32'h40000000;
      32'h40000000: return 32'h40400000;
      32'h40400000: return 32'h40800000;
      default:      return 32'hFFFFFFFF;
    endcase
  endfunction

  // Slave stub: samples ci_start, then raises ci_done lat cycles later with ci_datab + 1.0.
  always @(posedge clk) begin
    if (reset || !ci_clk_en) begin
      stub_cnt <= 0;
      ci_done  <= 1'b0;
    end else begin
      ci_done <= 1'b0;
      if (ci_start) begin
        stub_cnt  <= lat;
        stub_held <= ci_datab;
      end else if (stub_cnt != 0) begin
        stub_cnt <= stub_cnt - 1;
        if (stub_cnt == 1 && !stub_dead) begin
          ci_done   <= 1'b1;
          ci_result <= plus_one(stub_held);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (ci_start) begin
        starts <= starts + 1;
        dataa_q.push_back(ci_dataa);
        datab_q.push_back(ci_datab);
      end
      if (busy && !ci_clk_en && !result_valid) gaps <= gaps + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_sample(input logic [31:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
  endtask

  // Pulses run and returns the number of edges from the run edge to result_valid.
  task automatic run_and_wait(output int cycles);
    run = 1'b1;
    step();
    run = 1'b0;
    cycles = 1;
    while (!result_valid && cycles < 500) begin
      step();
      cycles++;
    end
  endtask

  int cyc, s0, q0, g0;

  initial begin
    ci_result = FP_ZERO;
    reset = 1'b1; wr_valid = 1'b0; wr_data = '0; run = 1'b0;
    repeat (3) step();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rv", {31'd0, result_valid}, 32'd0);
    check("rst_err", {31'd0, error}, 32'd0);
    check("rst_clk_en", {31'd0, ci_clk_en}, 32'd0);
    check("rst_start", {31'd0, ci_start}, 32'd0);
    check("rst_dataa", ci_dataa, 32'd0);
    check("rst_datab", ci_datab, 32'd0);
    check("rst_result", result, 32'd0);
    reset = 1'b0;
    step();
    check("rst_wr_ready", {31'd0, wr_ready}, 32'd1);

    // One sample, L=5
    lat = 5;
    push_sample(32'h40000000);
    s0 = starts; q0 = dataa_q.size();
    run_and_wait(cyc);
    check("one_latency", cyc, 32'd8);
    check("one_result", result, 32'h3F800000);
    check("one_error", {31'd0, error}, 32'd0);
    check("one_starts", starts - s0, 32'd1);
    check("one_dataa", dataa_q[q0], 32'h40000000);
    check("one_datab", datab_q[q0], 32'h00000000);
    step();

    // Three samples, L=4
    lat = 4;
    push_sample(32'h3F800000);
    push_sample(32'h40000000);
    push_sample(32'h40400000);
    s0 = starts; q0 = datab_q.size(); g0 = gaps;
    run_and_wait(cyc);
    check("three_starts", starts - s0, 32'd3);
    check("three_datab0", datab_q[q0], 32'h00000000);
    check("three_datab1", datab_q[q0+1], 32'h3F800000);
    check("three_datab2", datab_q[q0+2], 32'h40000000);
    check("three_dataa1", dataa_q[q0+1], 32'h40000000);
    check("three_gaps", gaps - g0, 32'd2);
    check("three_result", result, 32'h40400000);
    step();

    // Fill to DEPTH, reject overflow, ignore writes and run while busy
    lat = 1;
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("fill_ready%0d", i), {31'd0, wr_ready}, 32'd1);
      push_sample(32'h3F800000);
    end
    check("full_ready", {31'd0, wr_ready}, 32'd0);
    push_sample(32'h41200000);
    run = 1'b1;
    step();
    wr_valid = 1'b1; wr_data = 32'h41200000;
    check("busy_flag", {31'd0, busy}, 32'd1);
    check("busy_ready", {31'd0, wr_ready}, 32'd0);
    step();
    wr_valid = 1'b0; run = 1'b0;
    cyc = 2;
    while (!result_valid && cyc < 500) begin
      step();
      cyc++;
    end
    check("full_result", result, 32'h40800000);
    step();
    run_and_wait(cyc);
    check("after_full_lat", cyc, 32'd1);
    check("after_full_result", result, 32'h00000000);
    step();

    // Timeout: slave never answers
    stub_dead = 1'b1;
    push_sample(32'h40000000);
    push_sample(32'h40000000);
    run_and_wait(cyc);
    check("to_latency", cyc, TIMEOUT + 2);
    check("to_error", {31'd0, error}, 32'd1);
    check("to_clk_en", {31'd0, ci_clk_en}, 32'd0);
    check("to_result", result, 32'h00000000);
    step();
    check("to_err_hold", {31'd0, error}, 32'd1);
    check("to_idle_ready", {31'd0, wr_ready}, 32'd1);
    stub_dead = 1'b0;
    run_and_wait(cyc);
    check("to_flushed_lat", cyc, 32'd1);
    check("to_err_clear", {31'd0, error}, 32'd0);
    step();

    // Reset while waiting on the slave
    lat = 10;
    push_sample(32'h40000000);
    run = 1'b1;
    step();
    run = 1'b0;
    repeat (3) step();
    check("mid_clk_en", {31'd0, ci_clk_en}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_clk_en0", {31'd0, ci_clk_en}, 32'd0);
    check("mid_start", {31'd0, ci_start}, 32'd0);
    check("mid_datab", ci_datab, 32'd0);
    check("mid_dataa", ci_dataa, 32'd0);
    check("mid_result", result, 32'd0);
    step();
    check("mid_wr_ready", {31'd0, wr_ready}, 32'd1);
    run_and_wait(cyc);
    check("mid_empty_lat", cyc, 32'd1);
    check("mid_empty_result", result, 32'h00000000);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
